// File: rtl/pmoddac.sv
// SPI master transmitter for a Pmod DAC: takes samples over AXI4-Stream and
// shifts each one out MSB-first inside its own chip-select frame.
module pmoddac #(
   parameter int CLK_TRIG     = 0,
   parameter int SAMPLE_WIDTH = 16,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    axis_slave_valid,
   output logic                    axis_slave_ready,
   input  logic [SAMPLE_WIDTH-1:0] axis_slave_data,
   output logic                    spi_clock,
   output logic                    spi_chipselect,
   output logic                    spi_data
);

   localparam int HW = (CLK_TRIG > 0) ? $clog2(CLK_TRIG + 1) : 1;
   localparam int BW = $clog2(SAMPLE_WIDTH + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [1:0] STATE_IDLE  = 2'd0;
   localparam logic [1:0] STATE_SHIFT = 2'd1;
   localparam logic [1:0] STATE_GAP   = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [HW-1:0]           halfCnt_q, halfCnt_d;
   logic [BW-1:0]           bitCnt_q, bitCnt_d;
   logic [GW-1:0]           gapCnt_q, gapCnt_d;
   logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
   logic                    ready_q, ready_d;
   logic                    sclk_q, sclk_d;
   logic                    cs_q, cs_d;
   logic                    data_q, data_d;

   // Next-state logic. Data moves on SPI rising edges; the frame closes on the
   // rising edge that follows the last falling edge, so each bit is centred on
   // the falling edge where the DAC samples it.
   always_comb begin
      state_d   = state_q;
      halfCnt_d = halfCnt_q;
      bitCnt_d  = bitCnt_q;
      gapCnt_d  = gapCnt_q;
      shift_d   = shift_q;
      ready_d   = ready_q;
      sclk_d    = sclk_q;
      cs_d      = cs_q;
      data_d    = data_q;

      case (state_q)
         STATE_IDLE: begin
            ready_d = 1'b1;
            sclk_d  = 1'b1;
            cs_d    = 1'b1;
            data_d  = 1'b0;
            if (axis_slave_valid && ready_q) begin
               shift_d   = axis_slave_data;
               data_d    = axis_slave_data[SAMPLE_WIDTH-1];
               cs_d      = 1'b0;
               ready_d   = 1'b0;
               halfCnt_d = '0;
               bitCnt_d  = '0;
               state_d   = STATE_SHIFT;
            end
         end

         STATE_SHIFT: begin
            if (halfCnt_q == HW'(CLK_TRIG)) begin
               halfCnt_d = '0;
               if (sclk_q) begin
                  sclk_d   = 1'b0;
                  bitCnt_d = bitCnt_q + BW'(1);
               end else if (bitCnt_q == BW'(SAMPLE_WIDTH)) begin
                  sclk_d   = 1'b1;
                  cs_d     = 1'b1;
                  data_d   = 1'b0;
                  gapCnt_d = '0;
                  state_d  = STATE_GAP;
               end else begin
                  sclk_d  = 1'b1;
                  shift_d = {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
                  data_d  = shift_q[SAMPLE_WIDTH-2];
               end
            end else begin
               halfCnt_d = halfCnt_q + HW'(1);
            end
         end

         STATE_GAP: begin
            if (gapCnt_q == GW'(GAP_CYCLES)) begin
               ready_d = 1'b1;
               state_d = STATE_IDLE;
            end else begin
               gapCnt_d = gapCnt_q + GW'(1);
            end
         end

         default: begin
            state_d = STATE_IDLE;
         end
      endcase
   end

   // Reset abandons any frame in flight and parks the bus in its idle levels.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= STATE_IDLE;
         halfCnt_q <= '0;
         bitCnt_q  <= '0;
         gapCnt_q  <= '0;
         shift_q   <= '0;
         ready_q   <= 1'b0;
         sclk_q    <= 1'b1;
         cs_q      <= 1'b1;
         data_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         halfCnt_q <= halfCnt_d;
         bitCnt_q  <= bitCnt_d;
         gapCnt_q  <= gapCnt_d;
         shift_q   <= shift_d;
         ready_q   <= ready_d;
         sclk_q    <= sclk_d;
         cs_q      <= cs_d;
         data_q    <= data_d;
      end
   end

   assign axis_slave_ready = ready_q;
   assign spi_clock        = sclk_q;
   assign spi_chipselect   = cs_q;
   assign spi_data         = data_q;

endmodule
